// File: rtl/nibble_add_pkg.sv
// Package: nibble_add_pkg
// Shared types and constants for the nibble-serial adder.
//   state_t   : controller states IDLE / RUN / DONE
//   SLICE_W   : width of the single ripple-carry slice (one nibble)
//   idx_width : width of the nibble index counter, never narrower than 1 bit
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int SLICE_W = 4;

    // $clog2(1) is 0, which would leave a single-nibble build without an index.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_sequencer_add_nibble.sv
// Module: add_nibble
// Combinational 4-bit ripple-carry slice built from per-bit full adders.
// Ports:
//   x, y : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
module add_nibble
    import nibble_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Module: nibble_add_sequencer
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit ripple slice, one
// nibble per cycle, LSB nibble first. Valid/ready handshakes on both sides;
// one operation in flight at a time.
// Optional feature: define NIBBLE_ADD_SUB_EN to add the `sub` port
// (a - b computed as a + ~b + 1).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake; a, b, cin (and sub) sampled on it
//   out_valid/out_ready : result handshake; sum, cout, ovf stable while valid
//   sum                 : WIDTH-bit result (modulo 2^WIDTH)
//   cout                : carry out of the MSB (for subtraction: 1 = no borrow)
//   ovf                 : two's-complement signed overflow
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               carry;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic               accept;
    logic               last;
    logic [SLICE_W-1:0] slice_x, slice_y, slice_s;
    logic               slice_co;

    // Effective B operand and carry-in, resolved at the input handshake.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef NIBBLE_ADD_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
    end

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (idx == LAST_IDX);

    // The operand registers shift right one nibble per RUN cycle, so the
    // slice always sees the current nibble in bits [3:0].
    assign slice_x = a_r[SLICE_W-1:0];
    assign slice_y = b_r[SLICE_W-1:0];

    add_nibble u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // NOTE: next-state logic assigns its default first so no path leaves
    // state_nx unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx   <= '0;
                        carry <= cin_eff;
                    end
                end
                RUN: begin
                    carry <= slice_co;
                    // Each slice result enters at the top; after NIB cycles
                    // nibble k has settled at sum[4k +: 4].
                    sum   <= (sum >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
                    if (last) begin
                        cout <= slice_co;
                        // On the last nibble bit 3 of each operand is its MSB.
                        ovf  <= (slice_x[SLICE_W-1] == slice_y[SLICE_W-1]) &
                                (slice_s[SLICE_W-1] != slice_x[SLICE_W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand registers are pure datapath storage and are never read
    // before a handshake loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b_eff;
        end else if (state == RUN) begin
            a_r <= a_r >> SLICE_W;
            b_r <= b_r >> SLICE_W;
        end
    end

endmodule
